// File: rtl/heap_pqueue.sv
// heap_pqueue: binary-heap priority queue with push/pop/replace/clear, one heap level per cycle.
// Ports: clk, reset (async, active-high); start/op/key request accepted while ready;
// done pulses one cycle with error; result = key removed by last pop/replace;
// top/count/empty/full describe the current heap.
module heap_pqueue #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter int MIN_HEAP = 0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] key,
  output logic              ready,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] top,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_UP, S_DOWN, S_DONE} state_t;
  localparam logic [AW:0] ONE = (AW+1)'(1);
  state_t r_state, w_next;
  logic [1:0] r_op;
  logic [DATA_W-1:0] r_key, r_res, r_top;
  logic [DATA_W-1:0] r_arr [DEPTH];
  logic [AW:0] r_cnt;
  logic [AW-1:0] r_i, w_par, w_c, w_last, w_wa;
  logic [AW+1:0] w_l, w_r;
  logic r_err, w_rej, w_up, w_dn;
  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (MIN_HEAP != 0) ? (a < b) : (a > b);
  endfunction
  assign empty = r_cnt == '0;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign count = r_cnt;
  assign top = r_top;
  assign result = r_res;
  assign w_last = r_cnt[AW-1:0] - 1'b1;
  assign w_wa = r_op == 2'b00 ? r_cnt[AW-1:0] : '0;
  // parent wraps when i==0, but w_up is gated by i!=0
  assign w_par = (r_i - 1'b1) >> 1;
  assign w_l = {1'b0, r_i, 1'b1};
  assign w_r = {1'b0, r_i, 1'b0} + (AW+2)'(2);
  // left child wins ties so equal siblings never reorder
  assign w_c = (w_r < {1'b0, r_cnt} && better(r_arr[w_r[AW-1:0]], r_arr[w_l[AW-1:0]])) ? w_r[AW-1:0] : w_l[AW-1:0];
  assign w_up = r_i != '0 && better(r_arr[r_i], r_arr[w_par]);
  assign w_dn = w_l < {1'b0, r_cnt} && better(r_arr[w_c], r_arr[r_i]);
  assign w_rej = r_op == 2'b00 ? full : (r_op != 2'b11 && empty);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = start ? S_LOAD : S_IDLE;
      S_LOAD: w_next = (w_rej || r_op == 2'b11) ? S_DONE : (r_op == 2'b00 ? S_UP : S_DOWN);
      S_UP: w_next = w_up ? S_UP : S_DONE;
      S_DOWN: w_next = w_dn ? S_DOWN : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    ready = r_state == S_IDLE;
    done = r_state == S_DONE;
    error = done && r_err;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op <= '0;
      r_key <= '0;
      r_cnt <= '0;
      r_i <= '0;
      r_res <= '0;
      r_err <= 1'b0;
      r_top <= '0;
    end else begin
      // sifting ends with a non-modifying compare cycle, so sampling the root here is current by DONE
      r_top <= ((r_state == S_LOAD && r_op == 2'b11) || r_cnt == '0) ? '0 : r_arr[0];
      if (r_state == S_IDLE && start) begin
        r_op <= op;
        r_key <= key;
      end
      if (r_state == S_LOAD) begin
        r_err <= w_rej;
        if (!w_rej) begin
          r_i <= w_wa;
          r_cnt <= r_op == 2'b00 ? r_cnt + ONE : r_op == 2'b01 ? r_cnt - ONE : r_op == 2'b11 ? '0 : r_cnt;
          if (r_op[0] ^ r_op[1]) r_res <= r_arr[0];
        end
      end
      if (r_state == S_UP && w_up) r_i <= w_par;
      if (r_state == S_DOWN && w_dn) r_i <= w_c;
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && !w_rej && r_op != 2'b11) r_arr[w_wa] <= r_op == 2'b01 ? r_arr[w_last] : r_key;
    else if (r_state == S_UP && w_up) begin
      r_arr[r_i] <= r_arr[w_par];
      r_arr[w_par] <= r_arr[r_i];
    end else if (r_state == S_DOWN && w_dn) begin
      r_arr[r_i] <= r_arr[w_c];
      r_arr[w_c] <= r_arr[r_i];
    end
  end
endmodule

// File: tb/tb_heap_pqueue.sv
// tb_heap_pqueue: directed self-checking bench for a max-heap and a min-heap instance.
module tb_heap_pqueue;
  logic clk = 1'b0;
  logic rst [2];
  logic start [2];
  logic [1:0] op [2];
  logic [15:0] key [2];
  logic ready [2], done [2], error [2], empty [2], full [2];
  logic [15:0] result [2], top [2];
  logic [2:0] count [2];
  int checks = 0;
  int fails = 0;
  int lat;
  always #5 clk = ~clk;
  heap_pqueue #(.DATA_W(16), .DEPTH(4), .MIN_HEAP(0)) u_max (
    .clk(clk), .reset(rst[0]), .start(start[0]), .op(op[0]), .key(key[0]),
    .ready(ready[0]), .done(done[0]), .error(error[0]), .result(result[0]),
    .top(top[0]), .count(count[0]), .empty(empty[0]), .full(full[0]));
  heap_pqueue #(.DATA_W(16), .DEPTH(4), .MIN_HEAP(1)) u_min (
    .clk(clk), .reset(rst[1]), .start(start[1]), .op(op[1]), .key(key[1]),
    .ready(ready[1]), .done(done[1]), .error(error[1]), .result(result[1]),
    .top(top[1]), .count(count[1]), .empty(empty[1]), .full(full[1]));
  task automatic do_op(input int s, input logic [1:0] o, input logic [15:0] k, output int l);
    @(negedge clk);
    start[s] = 1'b1;
    op[s] = o;
    key[s] = k;
    @(negedge clk);
    start[s] = 1'b0;
    l = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done[s]) begin
        l = c;
        break;
      end
      @(negedge clk);
    end
    if (l == 0) begin
      checks++;
      fails++;
      $display("FAIL done_timeout inst=%0d op=%0d got=no_done exp=done", s, o);
    end
  endtask
  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({ready[s], done[s], error[s], empty[s], full[s]} !== 5'b10010) begin
        fails++;
        $display("FAIL reset_flags inst=%0d got=%b exp=10010", s, {ready[s], done[s], error[s], empty[s], full[s]});
      end
      checks++;
      if ({result[s], top[s], count[s]} !== 35'd0) begin
        fails++;
        $display("FAIL reset_values inst=%0d got=%0d/%0d/%0d exp=0/0/0", s, result[s], top[s], count[s]);
      end
    end
  endtask
  task automatic test_max_pop;
    logic [15:0] pk [4] = '{16'd5, 16'd9, 16'd3, 16'd7};
    logic [15:0] ex [4] = '{16'd9, 16'd7, 16'd5, 16'd3};
    foreach (pk[j]) do_op(0, 2'b00, pk[j], lat);
    checks++;
    if (top[0] !== 16'd9 || count[0] !== 3'd4 || full[0] !== 1'b1) begin
      fails++;
      $display("FAIL max_push top/count/full got=%0d/%0d/%b exp=9/4/1", top[0], count[0], full[0]);
    end
    foreach (ex[j]) begin
      do_op(0, 2'b01, 16'd0, lat);
      checks++;
      if (result[0] !== ex[j] || error[0] !== 1'b0) begin
        fails++;
        $display("FAIL max_pop%0d result/error got=%0d/%b exp=%0d/0", j, result[0], error[0], ex[j]);
      end
    end
    checks++;
    if (empty[0] !== 1'b1 || top[0] !== 16'd0) begin
      fails++;
      $display("FAIL max_drained empty/top got=%b/%0d exp=1/0", empty[0], top[0]);
    end
    do_op(0, 2'b01, 16'd0, lat);
    checks++;
    if (error[0] !== 1'b1 || result[0] !== 16'd3 || lat != 2) begin
      fails++;
      $display("FAIL pop_empty error/result/lat got=%b/%0d/%0d exp=1/3/2", error[0], result[0], lat);
    end
  endtask
  task automatic test_full;
    for (int j = 1; j <= 4; j++) do_op(0, 2'b00, 16'(j), lat);
    checks++;
    if (full[0] !== 1'b1 || top[0] !== 16'd4) begin
      fails++;
      $display("FAIL fill full/top got=%b/%0d exp=1/4", full[0], top[0]);
    end
    do_op(0, 2'b00, 16'd5, lat);
    checks++;
    if (error[0] !== 1'b1 || count[0] !== 3'd4 || top[0] !== 16'd4 || lat != 2) begin
      fails++;
      $display("FAIL push_full error/count/top/lat got=%b/%0d/%0d/%0d exp=1/4/4/2", error[0], count[0], top[0], lat);
    end
  endtask
  task automatic test_latency;
    do_op(0, 2'b11, 16'd0, lat);
    do_op(0, 2'b00, 16'd42, lat);
    checks++;
    if (lat != 3 || top[0] !== 16'd42 || count[0] !== 3'd1 || error[0] !== 1'b0) begin
      fails++;
      $display("FAIL push42 lat/top/count/error got=%0d/%0d/%0d/%b exp=3/42/1/0", lat, top[0], count[0], error[0]);
    end
    do_op(0, 2'b00, 16'd50, lat);
    checks++;
    if (lat != 4 || top[0] !== 16'd50 || count[0] !== 3'd2) begin
      fails++;
      $display("FAIL push50 lat/top/count got=%0d/%0d/%0d exp=4/50/2", lat, top[0], count[0]);
    end
  endtask
  task automatic test_equal_clear;
    do_op(0, 2'b11, 16'd0, lat);
    do_op(0, 2'b00, 16'd7, lat);
    do_op(0, 2'b00, 16'd7, lat);
    checks++;
    if (lat != 3 || count[0] !== 3'd2 || top[0] !== 16'd7) begin
      fails++;
      $display("FAIL equal_push lat/count/top got=%0d/%0d/%0d exp=3/2/7", lat, count[0], top[0]);
    end
    do_op(0, 2'b11, 16'd0, lat);
    checks++;
    if (lat != 2 || count[0] !== 3'd0 || top[0] !== 16'd0 || error[0] !== 1'b0 || empty[0] !== 1'b1) begin
      fails++;
      $display("FAIL clear lat/count/top/error/empty got=%0d/%0d/%0d/%b/%b exp=2/0/0/0/1", lat, count[0], top[0], error[0], empty[0]);
    end
  endtask
  task automatic test_min;
    do_op(1, 2'b00, 16'd8, lat);
    do_op(1, 2'b00, 16'd2, lat);
    do_op(1, 2'b00, 16'd6, lat);
    checks++;
    if (top[1] !== 16'd2 || count[1] !== 3'd3) begin
      fails++;
      $display("FAIL min_push top/count got=%0d/%0d exp=2/3", top[1], count[1]);
    end
    do_op(1, 2'b10, 16'd10, lat);
    checks++;
    if (result[1] !== 16'd2 || top[1] !== 16'd6 || count[1] !== 3'd3 || error[1] !== 1'b0 || lat != 4) begin
      fails++;
      $display("FAIL min_replace result/top/count/error/lat got=%0d/%0d/%0d/%b/%0d exp=2/6/3/0/4", result[1], top[1], count[1], error[1], lat);
    end
    do_op(1, 2'b01, 16'd0, lat);
    checks++;
    if (result[1] !== 16'd6 || top[1] !== 16'd8 || count[1] !== 3'd2) begin
      fails++;
      $display("FAIL min_pop result/top/count got=%0d/%0d/%0d exp=6/8/2", result[1], top[1], count[1]);
    end
  endtask
  task automatic test_abort;
    logic seen;
    do_op(0, 2'b11, 16'd0, lat);
    for (int j = 1; j <= 3; j++) do_op(0, 2'b00, 16'(j), lat);
    @(negedge clk);
    start[0] = 1'b1;
    op[0] = 2'b01;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (ready[0] !== 1'b1 || count[0] !== 3'd0 || done[0] !== 1'b0 || top[0] !== 16'd0) begin
      fails++;
      $display("FAIL abort_state ready/count/done/top got=%b/%0d/%b/%0d exp=1/0/0/0", ready[0], count[0], done[0], top[0]);
    end
    rst[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen |= done[0];
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort_done got=pulse exp=none");
    end
  endtask
  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1;
      start[s] = 1'b0;
      op[s] = 2'b00;
      key[s] = 16'd0;
    end
    repeat (2) @(negedge clk);
    test_reset;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    test_max_pop;
    test_full;
    test_latency;
    test_equal_clear;
    test_min;
    test_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
